// File: rtl/tenyr_mem_arb.sv
// ============================================================================
// Module   : tenyr_mem_arb
// Purpose  : Two-requester arbiter sharing one single-ported memory bus
//            between the tenyr core data port (m0) and a secondary master
//            (m1). Round-robin or fixed priority on ties, optional bus lock
//            to retain ownership across accesses, and a watchdog that
//            force-completes accesses the memory never finishes.
// Ports    : clk, reset_n          - clock, synchronous active-low reset
//            mX_req/rw/lock/addr/wdata - requester X access request
//            mX_ack/err/rdata      - requester X completion (one-cycle pulse)
//            mem_strobe/rw/addr/wdata - shared memory bus, driven for owner
//            mem_rdata/mem_ready   - memory response
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tenyr_mem_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR      = 1,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_rw,
    input  logic              m1_rw,
    input  logic              m0_lock,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic              m0_err,
    output logic              m1_err,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_strobe,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Counter only has to reach TIMEOUT-1; keep at least one bit so the
    // design still elaborates with the watchdog disabled.
    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit              WD_EN   = (TIMEOUT != 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [1:0]      state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q,  last_d;
    logic [WD_W-1:0] wd_q,    wd_d;

    logic            w_winner;
    logic            w_own_req;
    logic            w_own_lock;
    logic            w_timeout;

    // Tie-break: round-robin grants whoever did not win last time.
    assign w_winner   = (m0_req && m1_req) ? ((RR != 0) ? ~last_q : 1'b0) : m1_req;
    assign w_own_req  = owner_q ? m1_req  : m0_req;
    assign w_own_lock = owner_q ? m1_lock : m0_lock;
    assign w_timeout  = WD_EN && (wd_q == WD_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = S_BUSY;
                    owner_d = w_winner;
                    last_d  = w_winner;
                    wd_d    = '0;
                end
            end
            S_BUSY: begin
                if (mem_ready) begin
                    state_d = w_own_lock ? S_HOLD : S_IDLE;
                end else if (w_timeout) begin
                    // Forced completion never keeps the bus, lock or not.
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_HOLD: begin
                // The other requester is deliberately ignored here.
                if (w_own_req) begin
                    state_d = S_BUSY;
                    wd_d    = '0;
                end else if (!w_own_lock) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_strobe = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        m0_err     = 1'b0;
        m1_err     = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        if (state_q == S_BUSY) begin
            mem_strobe = 1'b1;
            mem_rw     = owner_q ? m1_rw    : m0_rw;
            mem_addr   = owner_q ? m1_addr  : m0_addr;
            mem_wdata  = owner_q ? m1_wdata : m0_wdata;
            // Ack fires even if the owner has dropped req mid-access.
            if (mem_ready || w_timeout) begin
                if (owner_q) begin
                    m1_ack   = 1'b1;
                    m1_err   = ~mem_ready;
                    m1_rdata = mem_ready ? mem_rdata : '0;
                end else begin
                    m0_ack   = 1'b1;
                    m0_err   = ~mem_ready;
                    m0_rdata = mem_ready ? mem_rdata : '0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tenyr_mem_arb.sv
// ============================================================================
// Module   : tb_tenyr_mem_arb
// Purpose  : Self-checking bench for tenyr_mem_arb. A table of per-cycle
//            input/expected-output records covers single access, ties,
//            locking, wait states, watchdog and mid-access reset; a short
//            hand-written sequence covers fixed-priority ties.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tenyr_mem_arb;

    localparam logic [31:0] A0  = 32'h0000_0100;
    localparam logic [31:0] A1  = 32'h0000_0200;
    localparam logic [31:0] WD0 = 32'hA0A0_A0A0;
    localparam logic [31:0] WD1 = 32'hB1B1_B1B1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m1_req, m0_rw, m1_rw, m0_lock, m1_lock;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        m0_ack, m1_ack, m0_err, m1_err, mem_strobe, mem_rw;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;

    logic        f_m0_ack, f_m1_ack, f_m0_err, f_m1_err, f_mem_strobe, f_mem_rw;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_mem_addr, f_mem_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tenyr_mem_arb #(.ADDR_W(32), .DATA_W(32), .RR(1), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_rw(m0_rw), .m1_rw(m1_rw),
        .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_addr(A0), .m1_addr(A1), .m0_wdata(WD0), .m1_wdata(WD1),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_err(m0_err), .m1_err(m1_err),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_strobe(mem_strobe), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    tenyr_mem_arb #(.ADDR_W(32), .DATA_W(32), .RR(0), .TIMEOUT(16)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_rw(m0_rw), .m1_rw(m1_rw),
        .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_addr(A0), .m1_addr(A1), .m0_wdata(WD0), .m1_wdata(WD1),
        .m0_ack(f_m0_ack), .m1_ack(f_m1_ack), .m0_err(f_m0_err), .m1_err(f_m1_err),
        .m0_rdata(f_m0_rdata), .m1_rdata(f_m1_rdata),
        .mem_strobe(f_mem_strobe), .mem_rw(f_mem_rw), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // ctl = {reset_n, m0_req, m0_rw, m0_lock, m1_req, m1_rw, m1_lock, mem_ready}
    // exp = {strobe, rw, addr, wdata, m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata}
    typedef struct {
        string        name;
        logic [7:0]   ctl;
        logic [31:0]  rdata;
        logic [133:0] exp;
    } vec_t;

    vec_t vecs[$];

    // bus: 0 = idle, 1 = m0 owns strobe, 2 = m1 owns strobe.
    // ack/err: bit 0 = m0, bit 1 = m1.
    task automatic add(input string nm, input logic [7:0] ctl, input logic [31:0] rdat,
                       input logic [1:0] bus, input logic mrw, input logic [1:0] ack,
                       input logic [1:0] err, input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t        v;
        logic [31:0] a;
        logic [31:0] w;
        a = (bus == 2'd1) ? A0  : (bus == 2'd2) ? A1  : 32'h0;
        w = (bus == 2'd1) ? WD0 : (bus == 2'd2) ? WD1 : 32'h0;
        v.name  = nm;
        v.ctl   = ctl;
        v.rdata = rdat;
        v.exp   = {(bus != 2'd0), mrw, a, w, ack[0], ack[1], err[0], err[1], rd0, rd1};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [7:0] ctl, input logic [31:0] rdat);
        {reset_n, m0_req, m0_rw, m0_lock, m1_req, m1_rw, m1_lock, mem_ready} = ctl;
        mem_rdata = rdat;
    endtask

    task automatic check_bit(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, act, req);
        end
    endtask

    initial begin
        logic [133:0] act;

        drive(8'b0_0_0_0_0_0_0_0, 32'h0);
        repeat (2) @(posedge clk);

        // ---- single read --------------------------------------------------
        add("reset_state", 8'b0_0_0_0_0_0_0_1, 32'hDEADBEEF, 0, 0, 2'b00, 2'b00, 0, 0);
        add("rd_idle",     8'b1_1_0_0_0_0_0_1, 32'hDEADBEEF, 0, 0, 2'b00, 2'b00, 0, 0);
        add("rd_busy",     8'b1_1_0_0_0_0_0_1, 32'hDEADBEEF, 1, 0, 2'b01, 2'b00, 32'hDEADBEEF, 0);
        add("rd_done",     8'b1_0_0_0_0_0_0_1, 32'hDEADBEEF, 0, 0, 2'b00, 2'b00, 0, 0);
        // ---- RR tie, both writing (last=0 so m1 first) ---------------------
        add("tie_idle1",   8'b1_1_1_0_1_1_0_1, 32'h12345678, 0, 0, 2'b00, 2'b00, 0, 0);
        add("tie_m1a",     8'b1_1_1_0_1_1_0_1, 32'h12345678, 2, 1, 2'b10, 2'b00, 0, 32'h12345678);
        add("tie_idle2",   8'b1_1_1_0_1_1_0_1, 32'h12345678, 0, 0, 2'b00, 2'b00, 0, 0);
        add("tie_m0",      8'b1_1_1_0_1_1_0_1, 32'h12345678, 1, 1, 2'b01, 2'b00, 32'h12345678, 0);
        add("tie_idle3",   8'b1_1_1_0_1_1_0_1, 32'h12345678, 0, 0, 2'b00, 2'b00, 0, 0);
        add("tie_m1b",     8'b1_1_1_0_1_1_0_1, 32'h12345678, 2, 1, 2'b10, 2'b00, 0, 32'h12345678);
        // ---- m1 locked for three accesses while m0 waits -------------------
        add("lk_idle",     8'b1_0_0_0_1_0_1_1, 32'hCAFE0001, 0, 0, 2'b00, 2'b00, 0, 0);
        add("lk_acc1",     8'b1_1_0_0_1_0_1_1, 32'hCAFE0001, 2, 0, 2'b10, 2'b00, 0, 32'hCAFE0001);
        add("lk_hold1",    8'b1_1_0_0_1_0_1_1, 32'hCAFE0001, 0, 0, 2'b00, 2'b00, 0, 0);
        add("lk_acc2",     8'b1_1_0_0_1_0_1_1, 32'hCAFE0002, 2, 0, 2'b10, 2'b00, 0, 32'hCAFE0002);
        add("lk_hold2",    8'b1_1_0_0_1_0_1_1, 32'hCAFE0002, 0, 0, 2'b00, 2'b00, 0, 0);
        add("lk_acc3",     8'b1_1_0_0_1_0_0_1, 32'hCAFE0003, 2, 0, 2'b10, 2'b00, 0, 32'hCAFE0003);
        // ---- m0 wins the tie after unlock, then three wait states ----------
        add("ws_idle",     8'b1_1_0_0_1_0_0_1, 32'h55AA55AA, 0, 0, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 3; i++)
            add($sformatf("ws_wait%0d", i), 8'b1_1_0_0_1_0_0_0, 32'h55AA55AA, 1, 0, 2'b00, 2'b00, 0, 0);
        add("ws_ack",      8'b1_1_0_0_1_0_0_1, 32'h55AA55AA, 1, 0, 2'b01, 2'b00, 32'h55AA55AA, 0);
        // ---- watchdog: m0 never completes, m1 waiting ----------------------
        add("wd_idle",     8'b1_1_0_0_0_0_0_0, 32'h77777777, 0, 0, 2'b00, 2'b00, 0, 0);
        for (int i = 1; i < 16; i++)
            add($sformatf("wd_busy%0d", i), 8'b1_1_0_0_1_0_0_0, 32'h77777777, 1, 0, 2'b00, 2'b00, 0, 0);
        add("wd_fire",     8'b1_1_0_0_1_0_0_0, 32'h77777777, 1, 0, 2'b01, 2'b01, 0, 0);
        add("wd_idle2",    8'b1_0_0_0_1_0_0_1, 32'h0BADF00D, 0, 0, 2'b00, 2'b00, 0, 0);
        add("wd_m1",       8'b1_0_0_0_1_0_0_1, 32'h0BADF00D, 2, 0, 2'b10, 2'b00, 0, 32'h0BADF00D);
        // ---- reset in the second BUSY cycle (last=0 before reset) ---------
        add("rs_idle",     8'b1_1_0_0_0_0_0_0, 32'h13579BDF, 0, 0, 2'b00, 2'b00, 0, 0);
        add("rs_busy1",    8'b1_1_0_0_0_0_0_0, 32'h13579BDF, 1, 0, 2'b00, 2'b00, 0, 0);
        add("rs_assert",   8'b0_1_0_0_0_0_0_0, 32'h13579BDF, 1, 0, 2'b00, 2'b00, 0, 0);
        add("rs_after",    8'b1_1_1_0_1_1_0_1, 32'h13579BDF, 0, 0, 2'b00, 2'b00, 0, 0);
        add("rs_tie_m0",   8'b1_1_1_0_1_1_0_1, 32'h13579BDF, 1, 1, 2'b01, 2'b00, 32'h13579BDF, 0);
        add("rs_end",      8'b1_0_0_0_0_0_0_1, 32'h13579BDF, 0, 0, 2'b00, 2'b00, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].ctl, vecs[i].rdata);
            #1;
            act = {mem_strobe, mem_rw, mem_addr, mem_wdata, m0_ack, m1_ack,
                   m0_err, m1_err, m0_rdata, m1_rdata};
            checks++;
            if (act !== vecs[i].exp) begin
                errors++;
                $display("FAIL row%0d %s: got %h want %h", i, vecs[i].name, act, vecs[i].exp);
            end
        end

        // ---- tie with both requesters held: RR alternates, fixed never serves m1
        @(negedge clk);
        drive(8'b0_0_0_0_0_0_0_1, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(8'b1_1_1_0_1_1_0_1, 32'h2468ACE0);
            #1;
            check_bit($sformatf("fp_m1_ack c%0d", i), f_m1_ack, 1'b0);
            check_bit($sformatf("fp_m0_ack c%0d", i), f_m0_ack, (i % 2) == 1);
            check_bit($sformatf("rr_m0_ack c%0d", i), m0_ack, (i % 4) == 1);
            check_bit($sformatf("rr_m1_ack c%0d", i), m1_ack, (i % 4) == 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tenyr_mem_arb.md
# tenyr_mem_arb

Two-requester arbiter that shares one single-ported memory bus between the tenyr core's data port (requester 0) and a secondary master such as a loader or debug DMA (requester 1). It accepts level-held requests, grants one owner at a time with round-robin or fixed priority, drives the shared memory bus for that owner, and returns a one-cycle acknowledge. Optional bus locking keeps ownership across back-to-back accesses. A watchdog terminates accesses the memory never completes.

## Interface
- `ADDR_W`, 32: address width in words.
- `DATA_W`, 32: data width.
- `RR`, 1: 1 = round-robin on ties; 0 = fixed priority, requester 0 wins.
- `TIMEOUT`, 16: cycles in BUSY without `mem_ready` before forced completion; 0 disables the watchdog.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `m0_req`, `m1_req` in 1: access request, level, held until ack.
- `m0_rw`, `m1_rw` in 1: 1 = write, 0 = read.
- `m0_lock`, `m1_lock` in 1: retain ownership after the current ack.
- `m0_addr`, `m1_addr` in ADDR_W: word address.
- `m0_wdata`, `m1_wdata` in DATA_W: write data.
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse.
- `m0_err`, `m1_err` out 1: valid with ack; 1 = watchdog termination.
- `m0_rdata`, `m1_rdata` out DATA_W: read data, valid with ack.
- `mem_strobe` out 1: bus cycle active.
- `mem_rw` out 1: owner's rw while strobing, else 0.
- `mem_addr` out ADDR_W: owner's address.
- `mem_wdata` out DATA_W: owner's write data.
- `mem_rdata` in DATA_W: memory read data.
- `mem_ready` in 1: memory completes the access this cycle.

## Operation
- State register: IDLE, BUSY, HOLD. Also `owner` (1 bit), `last` (1 bit, last granted requester) and `wd` (watchdog counter, wide enough for TIMEOUT).
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that requester.
  - Both request: if RR=1, grant `~last`; if RR=0, grant 0.
  - On grant: `owner` and `last` take the winner, `wd` clears, next state is BUSY.
- BUSY:
  - `mem_strobe`=1. `mem_rw`, `mem_addr` and `mem_wdata` are muxed combinationally from the owner's inputs.
  - `mem_ready`=1: the owner's ack pulses with `err`=0, and its rdata equals `mem_rdata` (combinational pass-through).
    - Next state is HOLD if the owner's lock is 1 in that cycle, otherwise IDLE.
  - `mem_ready`=0 with TIMEOUT≠0 and `wd`==TIMEOUT-1: the owner's ack and err pulse, rdata is 0, and next state is IDLE regardless of lock.
  - Otherwise `wd` increments.
- HOLD:
  - `mem_strobe`=0.
  - Owner req=1: go to BUSY with the same owner, `wd` clears. `last` is unchanged.
  - Owner lock=0 and req=0: go to IDLE.
  - The other requester is ignored while in HOLD.
- The non-owner's ack, err and rdata are always 0. Only one ack is ever asserted per cycle.
- If the owner drops req during BUSY (a protocol violation), the access still runs to completion and the ack is still pulsed.
- Outside BUSY, `mem_addr` and `mem_wdata` are 0.

## Timing
- Reset values: state=IDLE, `owner`=0, `last`=1 (requester 0 wins the first tie), `wd`=0. All outputs are 0.
- Reset mid-access: on the next edge `mem_strobe` drops and no ack is issued for the aborted access. The requester must re-request.
- Latency from req rising, sampled at edge k:
  - BUSY and `mem_strobe` are high from edge k+1.
  - With `mem_ready` tied high, ack occurs in the cycle after edge k+1.
  - Each wait state adds 1 cycle.
- Throughput with a zero-wait memory is one access per 2 cycles, both unlocked and locked (BUSY then IDLE or HOLD).
- Watchdog: ack and err occur in the TIMEOUT-th BUSY cycle.
- A req rising in the same cycle the other requester receives its ack is considered in the following IDLE cycle.

## Test plan
- Single read, RR=1, `mem_ready`=1: `m0_req`, addr 0x100, `mem_rdata`=0xDEADBEEF → strobe high for 1 cycle, `m0_ack` with rdata 0xDEADBEEF one cycle after req, `m1_ack` stays 0.
- Tie, RR=1: both requesters hold req continuously, each doing writes → grants alternate 0,1,0,1; `mem_addr` alternates between their addresses; each ack is 2 cycles apart. Same test with RR=0 → requester 1 is never granted.
- Lock: `m1_lock`=1 for 3 accesses while `m0_req` stays high → three consecutive m1 acks, then m0 is granted in the first IDLE after `m1_lock` falls.
- Wait states: `mem_ready` low for 3 BUSY cycles → strobe high for 4 cycles, ack on the 4th, `mem_addr` stable throughout.
- Watchdog, TIMEOUT=16: `mem_ready` never rises → `m0_ack` and `m0_err` in the 16th BUSY cycle, return to IDLE, and m1 is served next.
- Reset: assert `reset_n`=0 in the second BUSY cycle → strobe is 0 after the edge, no ack, state is IDLE, and the first tie after reset goes to requester 0.
